// File: rtl/ram32_fifo_pkg.sv
// Shared constants and helpers for the 32-deep distributed-RAM FIFO controller.
package ram32_fifo_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 6;

    // Occupancy after one cycle; accept gating guarantees no wrap.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cnt,
        input logic             push,
        input logic             pop
    );
        return cnt + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    endfunction

endpackage

// File: rtl/ram32_fifo_ctrl_flags.sv
// Status flags registered from the next-cycle occupancy so they align with COUNT.
module ram32_fifo_ctrl_flags
    import ram32_fifo_pkg::*;
#(
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [CNT_W-1:0] count_d_i,
    output logic             full_o,
    output logic             almost_full_o,
    output logic             empty_o,
    output logic             almost_empty_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    logic full_q;
    logic almost_full_q;
    logic empty_q;
    logic almost_empty_q;

    // Reset values match an occupancy of zero for any legal level setting.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
        end else begin
            full_q         <= (count_d_i == FULL_CNT);
            almost_full_q  <= (count_d_i >= AF_CNT);
            empty_q        <= (count_d_i == '0);
            almost_empty_q <= (count_d_i <= AE_CNT);
        end
    end

    assign full_o         = full_q;
    assign almost_full_o  = almost_full_q;
    assign empty_o        = empty_q;
    assign almost_empty_o = almost_empty_q;

endmodule

// File: rtl/ram32_fifo_ctrl.sv
// Pointer, count and error-flag control for a FIFO built on 32x1 dual-port RAM slices.
// The RAM writes on the falling edge of RAM_WCLK, so an accepted push lands mid-cycle.
module ram32_fifo_ctrl
    import ram32_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WR_EN,
    input  logic [WIDTH-1:0]  WR_DATA,
    output logic              FULL,
    output logic              ALMOST_FULL,
    input  logic              RD_EN,
    output logic [WIDTH-1:0]  RD_DATA,
    output logic              EMPTY,
    output logic              ALMOST_EMPTY,
    output logic [CNT_W-1:0]  COUNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    output logic              RAM_WCLK,
    output logic [ADDR_W-1:0] RAM_A,
    output logic [WIDTH-1:0]  RAM_D,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_DPRA,
    input  logic [WIDTH-1:0]  RAM_DPO
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic full;
    logic empty;
    logic push_ok;
    logic pop_ok;

    assign push_ok = WR_EN & ~full;
    assign pop_ok  = RD_EN & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{(ADDR_W-1){1'b0}}, push_ok};
        rd_ptr_d    = rd_ptr_q + {{(ADDR_W-1){1'b0}}, pop_ok};
        count_d     = next_count(count_q, push_ok, pop_ok);
        overflow_d  = overflow_q  | (WR_EN & full);
        underflow_d = underflow_q | (RD_EN & empty);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    ram32_fifo_ctrl_flags #(
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) u_flags (
        .clk_i          (CLK),
        .rst_n_i        (RST_N),
        .count_d_i      (count_d),
        .full_o         (full),
        .almost_full_o  (ALMOST_FULL),
        .empty_o        (empty),
        .almost_empty_o (ALMOST_EMPTY)
    );

    // Gating with RST_N keeps a reset cycle from writing a slot at the falling edge.
    assign RAM_WE    = push_ok & RST_N;
    assign RAM_WCLK  = CLK;
    assign RAM_A     = wr_ptr_q;
    assign RAM_D     = WR_DATA;
    assign RAM_DPRA  = rd_ptr_q;
    assign RD_DATA   = RAM_DPO;

    assign FULL      = full;
    assign EMPTY     = empty;
    assign COUNT     = count_q;
    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;

endmodule

// File: doc/ram32_fifo_ctrl.md
Name: ram32_fifo_ctrl

Overview:
- Synchronous 32-deep FIFO controller; sits directly upstream of a bank of WIDTH 32x1 dual-port distributed RAM primitives.
- Owns the pointers, flags and occupancy count. Drives the RAM write-port address, write enable, write data and write clock. Reads the bank's dual-port output bus asynchronously.
- The RAM bank writes on the falling edge of its write clock. This block registers everything on the rising edge, so each accepted write lands mid-cycle.

Parameters:
- WIDTH, 8, data width; equals the number of 32x1 RAM slices driven.
- AF_LEVEL, 28, ALMOST_FULL asserts when COUNT >= AF_LEVEL (legal range 1..32).
- AE_LEVEL, 4, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL (legal range 0..31).

Ports:
- CLK  in  1  single clock; all state on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- WR_EN  in  1  push request.
- WR_DATA  in  WIDTH  push data; held stable for the whole cycle.
- FULL  out  1  registered; COUNT == 32.
- ALMOST_FULL  out  1  registered.
- RD_EN  in  1  pop request.
- RD_DATA  out  WIDTH  head-of-FIFO data (show-ahead); valid when EMPTY == 0.
- EMPTY  out  1  registered; COUNT == 0.
- ALMOST_EMPTY  out  1  registered.
- COUNT  out  6  occupancy, 0..32.
- OVERFLOW  out  1  sticky; set by WR_EN while FULL.
- UNDERFLOW  out  1  sticky; set by RD_EN while EMPTY.
- RAM_WCLK  out  1  = CLK (pass-through buffer).
- RAM_A  out  5  write address = wr_ptr.
- RAM_D  out  WIDTH  = WR_DATA.
- RAM_WE  out  1  write enable.
- RAM_DPRA  out  5  read address = rd_ptr.
- RAM_DPO  in  WIDTH  async read data from the RAM bank.

Behaviour:
- Reset (RST_N low at a rising CLK):
  - wr_ptr, rd_ptr and COUNT go to 0.
  - EMPTY=1, ALMOST_EMPTY=1 (AE_LEVEL >= 0); FULL=0, ALMOST_FULL=0; OVERFLOW=0, UNDERFLOW=0.
  - RAM contents are not cleared; they are unobservable until rewritten.
- Accept rules:
  - push_ok = WR_EN & ~FULL.
  - pop_ok = RD_EN & ~EMPTY.
  - Both use the registered flag values from the start of the cycle.
- RAM_WE = push_ok & RST_N, combinational. No write occurs during a reset cycle, so a reset mid-operation never corrupts a slot.
- Write timing:
  - RAM_A changes only on the rising edge; the RAM captures RAM_D at the falling edge of the same cycle.
  - WR_DATA must be stable from the rising edge through the falling edge. Any synchronous driver in this clock domain meets this.
- On a rising edge with RST_N high:
  - wr_ptr += push_ok; rd_ptr += pop_ok.
  - Both pointers are 5-bit and wrap 31 -> 0 naturally.
  - COUNT += push_ok - pop_ok. The 6-bit count never wraps because of the accept gating.
  - Flags are recomputed from the next COUNT value and registered together with it.
- Read path:
  - RD_DATA = RAM_DPO, with RAM_DPRA = rd_ptr. No added latency.
  - A word pushed in cycle N is at RD_DATA, with EMPTY low, from the rising edge of N+1.
  - A pop advances the head at the next rising edge.
- Simultaneous events:
  - Push+pop while EMPTY: push accepted, pop rejected and UNDERFLOW set; COUNT goes 0->1.
  - Push+pop while FULL: pop accepted, push rejected and OVERFLOW set; COUNT goes 32->31.
  - Push+pop otherwise: both accepted; COUNT unchanged; pointers both advance.
- Sticky errors: OVERFLOW and UNDERFLOW set on the rising edge after the offending request. They clear only on reset.
- FULL case: wr_ptr == rd_ptr; disambiguated by COUNT, not by an extra pointer bit.

Decomposition:
- Shared package: DEPTH=32, ADDR_W=5, CNT_W=6 constants.
- One natural sub-module, ram32_fifo_flags: takes the next COUNT value and AF/AE levels, returns the registered FULL/EMPTY/ALMOST_FULL/ALMOST_EMPTY.
- The RAM bank stays outside; it is instantiated by the parent alongside this block.

Test Plan:
- Reset, then idle -> EMPTY=1, ALMOST_EMPTY=1, FULL=0, COUNT=0, RAM_WE=0, RAM_A=0, RAM_DPRA=0.
- Push 0xA5 in one cycle -> RAM_WE=1 with RAM_A=0 that cycle; next cycle EMPTY=0, COUNT=1, RD_DATA=0xA5. Pop -> EMPTY=1, RAM_DPRA=1.
- Push 32 values 0x00..0x1F -> FULL=1, COUNT=32, ALMOST_FULL asserted at COUNT=28.
  - 33rd push -> RAM_WE=0, OVERFLOW=1 next cycle.
  - Drain: RD_DATA yields 0x00..0x1F in order; EMPTY=1 after the 32nd pop.
- Push 40, pop 40 interleaved -> pointers wrap 31->0; data order preserved; COUNT ends at 0.
- Simultaneous push+pop at COUNT=32 -> COUNT=31, OVERFLOW=1. At COUNT=0 -> COUNT=1, UNDERFLOW=1. At COUNT=5 -> COUNT stays 5.
- RST_N low at COUNT=17 with WR_EN high -> RAM_WE=0 that cycle; next cycle COUNT=0, EMPTY=1, sticky flags clear.
